// File: rtl/vga_sync_decoder_if.sv
// ---------------------------------------------------------------------------------------------
// vga_sync_decoder_if
//   Bundles the VGA timing inputs and the recovered pixel/geometry/status outputs of the sync
//   decoder.
//   master : drives hsync_in/vsync_in/de_in (the video source), observes decoder outputs.
//   slave  : the decoder; consumes the sync inputs, drives everything else.
// Signals
//   hsync_in, vsync_in, de_in    active-high horizontal sync, vertical sync, display enable
//   pix_valid, hpos, vpos        current active pixel and its recovered x/y
//   line_len, frame_lines        clocks per line, lines per frame (last published frame)
//   active_w, active_h           DE-high clocks per line, DE lines per frame
//   locked, timing_err           lock status, one-cycle lock-loss pulse
// ---------------------------------------------------------------------------------------------
interface vga_sync_decoder_if #(
   parameter int unsigned CNT_W = 12
);
   logic             hsync_in;
   logic             vsync_in;
   logic             de_in;
   logic             pix_valid;
   logic [CNT_W-1:0] hpos;
   logic [CNT_W-1:0] vpos;
   logic [CNT_W-1:0] line_len;
   logic [CNT_W-1:0] frame_lines;
   logic [CNT_W-1:0] active_w;
   logic [CNT_W-1:0] active_h;
   logic             locked;
   logic             timing_err;

   modport master (
      output hsync_in,
      output vsync_in,
      output de_in,
      input  pix_valid,
      input  hpos,
      input  vpos,
      input  line_len,
      input  frame_lines,
      input  active_w,
      input  active_h,
      input  locked,
      input  timing_err
   );

   modport slave (
      input  hsync_in,
      input  vsync_in,
      input  de_in,
      output pix_valid,
      output hpos,
      output vpos,
      output line_len,
      output frame_lines,
      output active_w,
      output active_h,
      output locked,
      output timing_err
   );
endinterface

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------------------------
// vga_sync_decoder
//   Receive side of the VGA timing link. Measures line/frame geometry from active-high
//   hsync/vsync/DE, recovers hpos/vpos for every active pixel and reports lock / lock-loss.
// Ports
//   clk     pixel clock, one pixel per cycle
//   reset   asynchronous, active-high reset
//   bus     vga_sync_decoder_if.slave: sync inputs in; pixel position, geometry, status out
// Timing
//   Inputs are registered once (s1) with a delayed copy (s2) for edge detection; per-pixel
//   outputs are registered from s1, so pix_valid/hpos/vpos lag de_in by two clocks.
// ---------------------------------------------------------------------------------------------
module vga_sync_decoder #(
   parameter int unsigned CNT_W       = 12,
   parameter int unsigned LOCK_FRAMES = 2,
   parameter int unsigned TIMEOUT     = 4000
) (
   input  logic              clk,
   input  logic              reset,
   vga_sync_decoder_if.slave bus
);

   localparam logic [CNT_W-1:0] CntMax     = '1;
   localparam logic [CNT_W-1:0] TimeoutM1  = CNT_W'(TIMEOUT - 1);
   localparam logic [3:0]       LockTarget = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CntMax) ? v : v + CNT_W'(1);
   endfunction

   // Sync pipeline, bit order {hsync, vsync, de}
   logic [2:0]       s1_q, s1_d, s2_q, s2_d;
   state_e           state_q, state_d;
   logic [3:0]       match_q, match_d;

   // Running counters
   logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0] x_cnt_q, x_cnt_d;
   logic [CNT_W-1:0] rows_q, rows_d;
   logic [CNT_W-1:0] ln_cnt_q, ln_cnt_d;

   // Per-frame reference values and consistency tracking
   logic [CNT_W-1:0] frame_len_q, frame_len_d;
   logic [CNT_W-1:0] w_meas_q, w_meas_d;
   logic             first_h_q, first_h_d;
   logic             first_w_q, first_w_d;
   logic             line_ok_q, line_ok_d;

   // Published geometry
   logic [CNT_W-1:0] line_len_q, line_len_d;
   logic [CNT_W-1:0] frame_lines_q, frame_lines_d;
   logic [CNT_W-1:0] active_w_q, active_w_d;
   logic [CNT_W-1:0] active_h_q, active_h_d;

   // Per-pixel outputs and status
   logic             pix_valid_q, pix_valid_d;
   logic [CNT_W-1:0] hpos_q, hpos_d;
   logic [CNT_W-1:0] vpos_q, vpos_d;
   logic             timing_err_q, timing_err_d;

   // Decoded events
   logic             h_rise, v_rise, de_rise, de_fall;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] x_cur;
   logic             h_mismatch, w_mismatch;
   logic [CNT_W-1:0] frame_len_eff, w_eff, ln_eff, rows_eff;
   logic             line_ok_eff, same_set;
   logic             timeout_hit;
   logic             lock_h_err, lock_w_err, lock_f_err;
   logic [3:0]       match_inc, match_vrf;

   assign h_rise  = s1_q[2] & ~s2_q[2];
   assign v_rise  = s1_q[1] & ~s2_q[1];
   assign de_rise = s1_q[0] & ~s2_q[0];
   assign de_fall = ~s1_q[0] & s2_q[0];

   // h_cnt is cleared on the rise, so the full period ending here is one more than its value
   assign period = sat_inc(h_cnt_q);
   assign x_cur  = de_rise ? '0 : x_cnt_q;

   assign h_mismatch = h_rise & ~first_h_q & (period != frame_len_q);
   assign w_mismatch = de_fall & ~first_w_q & (x_cnt_q != w_meas_q);

   // End-of-frame view that folds in any hsync/DE event landing on the vsync rise cycle, so such
   // an event belongs to the frame that is ending.
   assign frame_len_eff = (h_rise & first_h_q) ? period : frame_len_q;
   assign w_eff         = (de_fall & first_w_q) ? x_cnt_q : w_meas_q;
   assign ln_eff        = h_rise ? sat_inc(ln_cnt_q) : ln_cnt_q;
   assign rows_eff      = de_fall ? sat_inc(rows_q) : rows_q;
   assign line_ok_eff   = line_ok_q & ~h_mismatch & ~w_mismatch;
   assign same_set      = (frame_len_eff == line_len_q) && (ln_eff == frame_lines_q) &&
                          (w_eff == active_w_q) && (rows_eff == active_h_q);

   // Fires on the cycle h_cnt steps onto TIMEOUT; a saturated counter never fires again
   assign timeout_hit = ~h_rise & (h_cnt_q == TimeoutM1);

   assign lock_h_err = h_rise & (period != line_len_q);
   assign lock_w_err = de_fall & (x_cnt_q != active_w_q);
   assign lock_f_err = v_rise & (~line_ok_eff | ~same_set);

   assign match_inc = (match_q == 4'hF) ? match_q : match_q + 4'd1;
   assign match_vrf = !line_ok_eff ? 4'd0 : (same_set ? match_inc : 4'd1);

   always_comb begin
      s1_d          = {bus.hsync_in, bus.vsync_in, bus.de_in};
      s2_d          = s1_q;
      state_d       = state_q;
      match_d       = match_q;
      h_cnt_d       = h_rise ? '0 : sat_inc(h_cnt_q);
      x_cnt_d       = x_cnt_q;
      rows_d        = rows_q;
      ln_cnt_d      = ln_cnt_q;
      frame_len_d   = frame_len_q;
      w_meas_d      = w_meas_q;
      first_h_d     = first_h_q;
      first_w_d     = first_w_q;
      line_ok_d     = line_ok_eff;
      line_len_d    = line_len_q;
      frame_lines_d = frame_lines_q;
      active_w_d    = active_w_q;
      active_h_d    = active_h_q;
      pix_valid_d   = s1_q[0];
      hpos_d        = x_cur;
      vpos_d        = rows_q;
      timing_err_d  = 1'b0;

      if (s1_q[0]) begin
         x_cnt_d = sat_inc(x_cur);
      end

      if (h_rise) begin
         ln_cnt_d = sat_inc(ln_cnt_q);
         if (first_h_q) begin
            frame_len_d = period;
            first_h_d   = 1'b0;
         end
      end

      if (de_fall) begin
         rows_d = sat_inc(rows_q);
         if (first_w_q) begin
            w_meas_d  = x_cnt_q;
            first_w_d = 1'b0;
         end
      end

      if (v_rise) begin
         ln_cnt_d  = '0;
         rows_d    = '0;
         line_ok_d = 1'b1;
         first_h_d = 1'b1;
         first_w_d = 1'b1;
         // A frame that began in SEARCH is partial and never published
         if (state_q != StSearch) begin
            line_len_d    = frame_len_eff;
            frame_lines_d = ln_eff;
            active_w_d    = w_eff;
            active_h_d    = rows_eff;
         end
      end

      unique case (state_q)
         StSearch: begin
            if (v_rise) begin
               state_d = StVerify;
               match_d = '0;
            end
         end
         StVerify: begin
            if (v_rise) begin
               match_d = match_vrf;
               if (match_vrf == LockTarget) begin
                  state_d = StLocked;
               end
            end
         end
         StLocked: begin
            if (lock_h_err | lock_w_err | lock_f_err) begin
               state_d      = StVerify;
               match_d      = '0;
               timing_err_d = 1'b1;
            end
         end
         default: begin
            state_d = StSearch;
            match_d = '0;
         end
      endcase

      // Loss of hsync overrides everything; only report it when leaving a non-SEARCH state
      if (timeout_hit) begin
         state_d      = StSearch;
         match_d      = '0;
         timing_err_d = (state_q != StSearch);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q          <= '0;
         s2_q          <= '0;
         state_q       <= StSearch;
         match_q       <= '0;
         h_cnt_q       <= '0;
         x_cnt_q       <= '0;
         rows_q        <= '0;
         ln_cnt_q      <= '0;
         frame_len_q   <= '0;
         w_meas_q      <= '0;
         first_h_q     <= 1'b1;
         first_w_q     <= 1'b1;
         line_ok_q     <= 1'b1;
         line_len_q    <= '0;
         frame_lines_q <= '0;
         active_w_q    <= '0;
         active_h_q    <= '0;
         pix_valid_q   <= 1'b0;
         hpos_q        <= '0;
         vpos_q        <= '0;
         timing_err_q  <= 1'b0;
      end else begin
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         state_q       <= state_d;
         match_q       <= match_d;
         h_cnt_q       <= h_cnt_d;
         x_cnt_q       <= x_cnt_d;
         rows_q        <= rows_d;
         ln_cnt_q      <= ln_cnt_d;
         frame_len_q   <= frame_len_d;
         w_meas_q      <= w_meas_d;
         first_h_q     <= first_h_d;
         first_w_q     <= first_w_d;
         line_ok_q     <= line_ok_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
         active_w_q    <= active_w_d;
         active_h_q    <= active_h_d;
         pix_valid_q   <= pix_valid_d;
         hpos_q        <= hpos_d;
         vpos_q        <= vpos_d;
         timing_err_q  <= timing_err_d;
      end
   end

   assign bus.pix_valid   = pix_valid_q;
   assign bus.hpos        = hpos_q;
   assign bus.vpos        = vpos_q;
   assign bus.line_len    = line_len_q;
   assign bus.frame_lines = frame_lines_q;
   assign bus.active_w    = active_w_q;
   assign bus.active_h    = active_h_q;
   assign bus.locked      = (state_q == StLocked);
   assign bus.timing_err  = timing_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ---------------------------------------------------------------------------------------------
// tb_vga_sync_decoder
//   Directed bench for vga_sync_decoder. A small raster generator drives the interface; expected
//   values are hand-computed from the generator geometry. The main raster is 100 x 50 clocks with
//   an 80 x 40 active area (scaled-down stand-in for 800x525 / 640x480); the coincident-sync case
//   uses 16 x 100 with hsync and vsync rising together.
// ---------------------------------------------------------------------------------------------
module tb_vga_sync_decoder;
   localparam int unsigned CntW = 12;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vga_sync_decoder_if #(.CNT_W(CntW)) vif ();

   vga_sync_decoder #(
      .CNT_W      (CntW),
      .LOCK_FRAMES(2),
      .TIMEOUT    (4000)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (vif.slave)
   );

   int checks = 0;
   int failures = 0;

   // Raster geometry and position
   int h_tot, h_act, hs_start, hs_end, v_tot, v_act, vs_line, vs_hc;
   int hc, vc;
   int cyc = 0;
   int short_vc = 0;
   bit short_arm = 1'b0;
   bit hold_hs = 1'b0;

   // Event bookkeeping
   int hs_rise_cyc = 0, hs_rise_vc = 0, vs_rise_cyc = 0, vs_cnt = 0;
   int err_cnt = 0, err_delay = 0, err_vc = 0;
   int lock_vs = 0, lock_delay = 0;
   bit locked_prev = 1'b0;
   int e0;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_main_geometry();
      h_tot = 100; h_act = 80; hs_start = 84; hs_end = 92;
      v_tot = 50;  v_act = 40; vs_line = 44;  vs_hc = 0;
   endtask

   task automatic drive();
      logic hs_n, vs_n, de_n;
      de_n = (hc < h_act) && (vc < v_act);
      hs_n = !hold_hs && (hc >= hs_start) && (hc < hs_end);
      vs_n = ((vc > vs_line) || (vc == vs_line && hc >= vs_hc)) &&
             ((vc < vs_line + 2) || (vc == vs_line + 2 && hc < vs_hc));
      if (hs_n && !vif.hsync_in) begin
         hs_rise_cyc = cyc;
         hs_rise_vc  = vc;
      end
      if (vs_n && !vif.vsync_in) begin
         vs_rise_cyc = cyc;
         vs_cnt++;
      end
      vif.hsync_in = hs_n;
      vif.vsync_in = vs_n;
      vif.de_in    = de_n;
   endtask

   task automatic restart();
      hc = 0;
      vc = 0;
      drive();
   endtask

   task automatic advance();
      int len;
      len = (short_arm && vc == short_vc) ? h_tot - 1 : h_tot;
      hc++;
      if (hc >= len) begin
         if (len != h_tot) short_arm = 1'b0;
         hc = 0;
         vc = (vc + 1 == v_tot) ? 0 : vc + 1;
      end
   endtask

   // One clock: sample DUT 1 time unit after the edge, then present the next raster position
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (vif.timing_err) begin
         err_cnt++;
         err_delay = cyc - hs_rise_cyc;
         err_vc    = hs_rise_vc;
      end
      if (vif.locked && !locked_prev) begin
         lock_vs    = vs_cnt;
         lock_delay = cyc - vs_rise_cyc;
      end
      locked_prev = vif.locked;
      advance();
      drive();
   endtask

   task automatic wait_pos(input int h, input int v, input int max_cyc, input string tag);
      int n = 0;
      while (!(hc == h && vc == v) && n < max_cyc) begin
         tick();
         n++;
      end
      if (!(hc == h && vc == v)) check_eq(tag, 0, 1);
   endtask

   task automatic wait_lock(input int max_cyc, input string tag);
      int n = 0;
      while (!vif.locked && n < max_cyc) begin
         tick();
         n++;
      end
      check_eq(tag, vif.locked, 1);
   endtask

   task automatic wait_err(input int base, input int max_cyc, input string tag);
      int n = 0;
      while (err_cnt == base && n < max_cyc) begin
         tick();
         n++;
      end
      check_eq(tag, err_cnt, base + 1);
   endtask

   task automatic check_all_zero(input string pfx);
      check_eq({pfx, "_pix_valid"}, vif.pix_valid, 0);
      check_eq({pfx, "_hpos"}, vif.hpos, 0);
      check_eq({pfx, "_vpos"}, vif.vpos, 0);
      check_eq({pfx, "_line_len"}, vif.line_len, 0);
      check_eq({pfx, "_frame_lines"}, vif.frame_lines, 0);
      check_eq({pfx, "_active_w"}, vif.active_w, 0);
      check_eq({pfx, "_active_h"}, vif.active_h, 0);
      check_eq({pfx, "_locked"}, vif.locked, 0);
      check_eq({pfx, "_timing_err"}, vif.timing_err, 0);
   endtask

   task automatic check_geometry(input string pfx, input int ll, input int fl, input int aw,
                                 input int ah);
      check_eq({pfx, "_line_len"}, vif.line_len, ll);
      check_eq({pfx, "_frame_lines"}, vif.frame_lines, fl);
      check_eq({pfx, "_active_w"}, vif.active_w, aw);
      check_eq({pfx, "_active_h"}, vif.active_h, ah);
   endtask

   initial begin
      vif.hsync_in = 1'b0;
      vif.vsync_in = 1'b0;
      vif.de_in    = 1'b0;
      set_main_geometry();

      // Reset state
      reset = 1'b1;
      restart();
      @(posedge clk);
      #1;
      check_all_zero("rst");
      reset = 1'b0;
      vs_cnt = 0;
      restart();

      // Lock from reset: SEARCH consumes rise 1, lock publishes with rise 3
      wait_lock(20000, "lock1_wait");
      check_eq("lock1_vs", lock_vs, 3);
      check_eq("lock1_delay", lock_delay, 2);
      check_geometry("lock1", 100, 50, 80, 40);
      check_eq("lock1_no_err", err_cnt, 0);

      // Pixel recovery, two clocks behind de_in
      wait_pos(0, 0, 6000, "pix0_wait");
      tick();
      tick();
      check_eq("pix0_valid", vif.pix_valid, 1);
      check_eq("pix0_hpos", vif.hpos, 0);
      check_eq("pix0_vpos", vif.vpos, 0);
      wait_pos(37, 12, 6000, "pixm_wait");
      tick();
      tick();
      check_eq("pixm_hpos", vif.hpos, 37);
      check_eq("pixm_vpos", vif.vpos, 12);
      wait_pos(79, 39, 6000, "pixl_wait");
      tick();
      tick();
      check_eq("pixl_valid", vif.pix_valid, 1);
      check_eq("pixl_hpos", vif.hpos, 79);
      check_eq("pixl_vpos", vif.vpos, 39);
      tick();
      check_eq("blank_valid", vif.pix_valid, 0);

      // Line 10 shortened to 99 clocks: flagged at the line-11 hsync rise
      short_vc  = 10;
      short_arm = 1'b1;
      e0 = err_cnt;
      wait_err(e0, 10000, "short_err_wait");
      check_eq("short_err_delay", err_delay, 2);
      check_eq("short_err_line", err_vc, 11);
      check_eq("short_unlocked", vif.locked, 0);
      vs_cnt = 0;
      wait_lock(20000, "short_relock_wait");
      check_eq("short_relock_vs", lock_vs, 3);
      check_eq("short_one_pulse", err_cnt, e0 + 1);

      // Asynchronous reset mid-frame while locked
      wait_pos(50, 20, 10000, "rst2_wait");
      check_eq("rst2_pre_locked", vif.locked, 1);
      reset = 1'b1;
      #1;
      check_all_zero("rst2");
      tick();
      reset = 1'b0;
      vs_cnt = 0;
      locked_prev = 1'b0;
      wait_lock(20000, "rst2_relock_wait");
      check_eq("rst2_relock_vs", lock_vs, 3);
      check_geometry("rst2", 100, 50, 80, 40);

      // hsync lost while locked: pulse exactly when h_cnt reaches 4000, no repeat afterwards
      wait_pos(0, 47, 6000, "to_wait");
      hold_hs = 1'b1;
      e0 = err_cnt;
      wait_err(e0, 6000, "to_err_wait");
      check_eq("to_err_delay", err_delay, 4002);
      check_eq("to_unlocked", vif.locked, 0);
      repeat (3000) tick();
      check_eq("to_no_repeat", err_cnt, e0 + 1);
      check_eq("to_still_unlocked", vif.locked, 0);
      check_eq("to_kept_line_len", vif.line_len, 100);
      check_eq("to_kept_frame_lines", vif.frame_lines, 50);
      hold_hs = 1'b0;

      // 100-line frames with hsync and vsync rising on the same cycle
      reset = 1'b1;
      h_tot = 16; h_act = 12; hs_start = 13; hs_end = 15;
      v_tot = 100; v_act = 90; vs_line = 95; vs_hc = 13;
      restart();
      tick();
      reset = 1'b0;
      vs_cnt = 0;
      locked_prev = 1'b0;
      wait_lock(12000, "coin_lock_wait");
      check_eq("coin_lock_vs", lock_vs, 3);
      check_geometry("coin", 16, 100, 12, 90);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
